bsg_manycore_dma_to_axi: RTL and testbench
==========================================

Name: bsg_manycore_dma_to_axi

Overview:
- Converts a cache-side DMA packet interface into single-ID AXI4 master bursts: one full-line read or write burst per packet.
- Sits between the manycore vcache DMA port and the AXI slave, either the testbench AXI memory model or a real DRAM controller.
- Allows one outstanding transaction at a time and strictly orders packets.

Parameters:
- addr_width_p, 32, DMA packet address width (byte address).
- axi_id_width_p, 6, AXI ID width.
- axi_addr_width_p, 64, AXI address width; must be >= addr_width_p.
- axi_data_width_p, 256, AXI data width = DMA beat width; must be a power of 2 and >= 32.
- axi_burst_len_p, 2, beats per line; must be >= 1.
- axi_id_p, 0, constant ID driven on awid/arid.
- Derived constant: lg_beat_bytes_lp = clog2(axi_data_width_p/8).
- Derived constant: lg_line_bytes_lp = lg_beat_bytes_lp + clog2(axi_burst_len_p).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- dma_pkt_v_i  in  1  packet valid
- dma_pkt_write_i  in  1  1=write line, 0=read line
- dma_pkt_addr_i  in  addr_width_p  line byte address
- dma_pkt_yumi_o  out  1  packet consumed
- dma_wdata_i  in  axi_data_width_p  write beat
- dma_wdata_v_i  in  1  write beat valid
- dma_wdata_yumi_o  out  1  write beat consumed
- dma_rdata_o  out  axi_data_width_p  read beat
- dma_rdata_v_o  out  1  read beat valid
- dma_rdata_ready_i  in  1  read beat accept
- axi_awid_o/awaddr_o/awlen_o[7:0]/awsize_o[2:0]/awburst_o[1:0]/awvalid_o  out; axi_awready_i  in
- axi_wdata_o  out  axi_data_width_p; axi_wstrb_o  out  axi_data_width_p/8; axi_wlast_o/axi_wvalid_o  out  1; axi_wready_i  in  1
- axi_bid_i  in  axi_id_width_p; axi_bresp_i  in  2; axi_bvalid_i  in  1; axi_bready_o  out  1
- axi_arid_o/araddr_o/arlen_o/arsize_o/arburst_o/arvalid_o  out; axi_arready_i  in
- axi_rid_i  in; axi_rdata_i  in; axi_rresp_i  in  2; axi_rlast_i/axi_rvalid_i  in  1; axi_rready_o  out  1
- err_o  out  1  sticky protocol/response error

Behaviour:
- Reset (reset_n_i=0, asynchronous): state=IDLE, beat counter=0, err_o=0, address register=0. All valid/ready/yumi outputs are 0 while in reset.
- Constant outputs:
  - awid/arid = axi_id_p
  - awlen/arlen = axi_burst_len_p-1
  - awsize/arsize = lg_beat_bytes_lp
  - awburst/arburst = 2'b01 (INCR)
  - wstrb = all ones
- Address: zero-extend dma_pkt_addr_i to axi_addr_width_p and clear bits [lg_line_bytes_lp-1:0]. Register it at packet accept.
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - dma_pkt_yumi_o = dma_pkt_v_i.
  - On accept, go to WR_ADDR if write=1, else RD_ADDR.
  - Clear the beat counter.
- WR_ADDR: awvalid_o=1 and held stable until awready; then go to WR_DATA. The W channel is not driven before the AW handshake.
- WR_DATA:
  - wvalid_o = dma_wdata_v_i; wdata_o = dma_wdata_i.
  - dma_wdata_yumi_o = wvalid & wready.
  - wlast_o = (counter == axi_burst_len_p-1).
  - Counter increments on each W handshake.
  - Last-beat handshake goes to WR_RESP.
- WR_RESP:
  - bready_o=1.
  - On bvalid, go to IDLE.
  - Set err_o if bresp != 0 or bid != axi_id_p.
- RD_ADDR: arvalid_o=1 and held until arready; then go to RD_DATA.
- RD_DATA:
  - dma_rdata_o = rdata; dma_rdata_v_o = rvalid; rready_o = dma_rdata_ready_i.
  - Counter increments on each R handshake.
  - Transaction ends on the handshake where counter == axi_burst_len_p-1; go to IDLE.
  - Set err_o if rlast_i disagrees with (counter == axi_burst_len_p-1), or rresp != 0, or rid != axi_id_p.
- Latency: packet accept -> awvalid/arvalid asserted the next cycle. Minimum write = burst_len+3 cycles accept-to-IDLE with a zero-wait slave.
- Back-to-back: the next packet is accepted only in IDLE, i.e. at least 1 cycle after B/last-R completes.
- Backpressure: any number of stall cycles on any channel; outputs stay stable while valid && !ready.
- burst_len=1: counter is 1 bit (safe clog2), wlast asserted on the first beat.
- Reset mid-operation: state and counter are abandoned. The slave must be reset in the same window; no recovery of partial bursts.
- err_o clears only on reset.

Decomposition:
- Package bsg_manycore_axi_pkg:
  - axi_burst_e (FIXED=0, INCR=1, WRAP=2)
  - axi_resp_e (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - dma_to_axi_state_e
- No sub-module: a single FSM plus a counter, reusing bsg_counter_clear_up for the beat counter.

Test Plan:
- Write 0x0000_0040 with beats {A0.., A1..}, slave ready always -> AW addr=0x40, len=1, size=5, burst=1; beat 1 carries wlast=1; B accepted; readback shows both beats at 0x40/0x60.
- Read 0x0000_0047 -> araddr=0x40 (aligned); two dma_rdata beats equal the stored data; return to IDLE.
- Read of an unwritten line from an uninitialised slave -> beats all 0xdeadbeef; err_o stays 0.
- Random stalls: awready/wready/rvalid toggled with 50% probability, dma_rdata_ready_i held 0 for 5 cycles -> data unchanged while stalled; no beats lost or duplicated over 1000 mixed packets checked against a scoreboard.
- Slave returns bresp=2 on one write -> err_o=1 the cycle after the B handshake and stays 1; the next packet is still processed.
- Assert reset_n_i during WR_DATA after beat 0 -> all outputs 0 asynchronously; after release, a new read completes correctly.

Source files
------------

// File: rtl/bsg_manycore_axi_pkg.sv
// Shared AXI encodings and DMA bridge FSM states for the manycore memory path.
package bsg_manycore_axi_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5
  } dma_to_axi_state_e;

  // Counter width that never collapses to zero bits for a count of one.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load 1.
// Single-cycle update, no flow control.
module bsg_counter_clear_up #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= up_i ? width_p'(1) : '0;
    end else if (up_i) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_manycore_dma_to_axi.sv
// Vcache DMA packet to single-ID AXI4 full-line bursts, one transaction in flight.
// AW/AR issue the cycle after packet accept; every channel tolerates arbitrary stalls.
module bsg_manycore_dma_to_axi
  import bsg_manycore_axi_pkg::*;
#(
  parameter int addr_width_p     = 32,
  parameter int axi_id_width_p   = 6,
  parameter int axi_addr_width_p = 64,
  parameter int axi_data_width_p = 256,
  parameter int axi_burst_len_p  = 2,
  parameter int axi_id_p         = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic                          dma_pkt_v_i,
  input  logic                          dma_pkt_write_i,
  input  logic [addr_width_p-1:0]       dma_pkt_addr_i,
  output logic                          dma_pkt_yumi_o,

  input  logic [axi_data_width_p-1:0]   dma_wdata_i,
  input  logic                          dma_wdata_v_i,
  output logic                          dma_wdata_yumi_o,

  output logic [axi_data_width_p-1:0]   dma_rdata_o,
  output logic                          dma_rdata_v_o,
  input  logic                          dma_rdata_ready_i,

  output logic [axi_id_width_p-1:0]     axi_awid_o,
  output logic [axi_addr_width_p-1:0]   axi_awaddr_o,
  output logic [7:0]                    axi_awlen_o,
  output logic [2:0]                    axi_awsize_o,
  output logic [1:0]                    axi_awburst_o,
  output logic                          axi_awvalid_o,
  input  logic                          axi_awready_i,

  output logic [axi_data_width_p-1:0]   axi_wdata_o,
  output logic [axi_data_width_p/8-1:0] axi_wstrb_o,
  output logic                          axi_wlast_o,
  output logic                          axi_wvalid_o,
  input  logic                          axi_wready_i,

  input  logic [axi_id_width_p-1:0]     axi_bid_i,
  input  logic [1:0]                    axi_bresp_i,
  input  logic                          axi_bvalid_i,
  output logic                          axi_bready_o,

  output logic [axi_id_width_p-1:0]     axi_arid_o,
  output logic [axi_addr_width_p-1:0]   axi_araddr_o,
  output logic [7:0]                    axi_arlen_o,
  output logic [2:0]                    axi_arsize_o,
  output logic [1:0]                    axi_arburst_o,
  output logic                          axi_arvalid_o,
  input  logic                          axi_arready_i,

  input  logic [axi_id_width_p-1:0]     axi_rid_i,
  input  logic [axi_data_width_p-1:0]   axi_rdata_i,
  input  logic [1:0]                    axi_rresp_i,
  input  logic                          axi_rlast_i,
  input  logic                          axi_rvalid_i,
  output logic                          axi_rready_o,

  output logic                          err_o
);

  localparam int lg_beat_bytes_lp = $clog2(axi_data_width_p/8);
  localparam int lg_line_bytes_lp = lg_beat_bytes_lp + $clog2(axi_burst_len_p);
  localparam int cnt_width_lp     = safe_clog2(axi_burst_len_p);

  localparam logic [axi_id_width_p-1:0]   id_lp        = axi_id_width_p'(axi_id_p);
  localparam logic [axi_addr_width_p-1:0] line_mask_lp = {axi_addr_width_p{1'b1}} << lg_line_bytes_lp;
  localparam logic [cnt_width_lp-1:0]     last_cnt_lp  = cnt_width_lp'(axi_burst_len_p - 1);

  dma_to_axi_state_e           state_r;
  logic [axi_addr_width_p-1:0] addr_r;
  logic [cnt_width_lp-1:0]     beat_cnt;
  logic                        err_r;
  logic                        last_beat;
  logic                        w_fire, r_fire;
  logic [axi_addr_width_p-1:0] line_addr;

  assign line_addr = axi_addr_width_p'(dma_pkt_addr_i) & line_mask_lp;
  assign last_beat = (beat_cnt == last_cnt_lp);

  // Reset gating keeps yumi low even though IDLE is the reset state.
  assign dma_pkt_yumi_o = reset_n_i & (state_r == IDLE) & dma_pkt_v_i;

  assign axi_awid_o    = id_lp;
  assign axi_awaddr_o  = addr_r;
  assign axi_awlen_o   = 8'(axi_burst_len_p - 1);
  assign axi_awsize_o  = 3'(lg_beat_bytes_lp);
  assign axi_awburst_o = AXI_BURST_INCR;
  assign axi_awvalid_o = (state_r == WR_ADDR);

  assign axi_wdata_o      = dma_wdata_i;
  assign axi_wstrb_o      = '1;
  assign axi_wvalid_o     = (state_r == WR_DATA) & dma_wdata_v_i;
  assign axi_wlast_o      = last_beat;
  assign w_fire           = axi_wvalid_o & axi_wready_i;
  assign dma_wdata_yumi_o = w_fire;

  assign axi_bready_o = (state_r == WR_RESP);

  assign axi_arid_o    = id_lp;
  assign axi_araddr_o  = addr_r;
  assign axi_arlen_o   = 8'(axi_burst_len_p - 1);
  assign axi_arsize_o  = 3'(lg_beat_bytes_lp);
  assign axi_arburst_o = AXI_BURST_INCR;
  assign axi_arvalid_o = (state_r == RD_ADDR);

  assign dma_rdata_o   = axi_rdata_i;
  assign dma_rdata_v_o = (state_r == RD_DATA) & axi_rvalid_i;
  assign axi_rready_o  = (state_r == RD_DATA) & dma_rdata_ready_i;
  assign r_fire        = axi_rvalid_i & axi_rready_o;

  assign err_o = err_r;

  bsg_counter_clear_up #(
    .width_p (cnt_width_lp)
  ) beat_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (state_r == IDLE),
    .up_i      (w_fire | r_fire),
    .count_o   (beat_cnt)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      addr_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dma_pkt_v_i) begin
            state_r <= dma_pkt_write_i ? WR_ADDR : RD_ADDR;
            addr_r  <= line_addr;
          end
        end
        WR_ADDR: if (axi_awready_i) state_r <= WR_DATA;
        WR_DATA: if (w_fire && last_beat) state_r <= WR_RESP;
        WR_RESP: begin
          if (axi_bvalid_i) begin
            state_r <= IDLE;
            if (axi_bresp_i != AXI_RESP_OKAY || axi_bid_i != id_lp) err_r <= 1'b1;
          end
        end
        RD_ADDR: if (axi_arready_i) state_r <= RD_DATA;
        RD_DATA: begin
          if (r_fire) begin
            // rlast must line up with our own beat count.
            if (axi_rlast_i != last_beat || axi_rresp_i != AXI_RESP_OKAY || axi_rid_i != id_lp)
              err_r <= 1'b1;
            if (last_beat) state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_dma_to_axi.sv
// Self-checking bench: AXI slave memory model with random stalls and a read-data scoreboard.
module tb_bsg_manycore_dma_to_axi;

  localparam int AW     = 32;
  localparam int IDW    = 6;
  localparam int AXAW   = 64;
  localparam int DW     = 256;
  localparam int BL     = 2;
  localparam int BEAT_B = DW/8;
  localparam int LINE_B = BEAT_B*BL;
  localparam logic [DW-1:0] DEADBEEF = {(DW/32){32'hdeadbeef}};

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            dma_pkt_v_i, dma_pkt_write_i, dma_pkt_yumi_o;
  logic [AW-1:0]   dma_pkt_addr_i;
  logic [DW-1:0]   dma_wdata_i;
  logic            dma_wdata_v_i, dma_wdata_yumi_o;
  logic [DW-1:0]   dma_rdata_o;
  logic            dma_rdata_v_o, dma_rdata_ready_i;
  logic [IDW-1:0]  axi_awid_o, axi_arid_o, axi_bid_i, axi_rid_i;
  logic [AXAW-1:0] axi_awaddr_o, axi_araddr_o;
  logic [7:0]      axi_awlen_o, axi_arlen_o;
  logic [2:0]      axi_awsize_o, axi_arsize_o;
  logic [1:0]      axi_awburst_o, axi_arburst_o, axi_bresp_i, axi_rresp_i;
  logic            axi_awvalid_o, axi_awready_i, axi_arvalid_o, axi_arready_i;
  logic [DW-1:0]   axi_wdata_o, axi_rdata_i;
  logic [DW/8-1:0] axi_wstrb_o;
  logic            axi_wlast_o, axi_wvalid_o, axi_wready_i;
  logic            axi_bvalid_i, axi_bready_o;
  logic            axi_rlast_i, axi_rvalid_i, axi_rready_o;
  logic            err_o;

  bsg_manycore_dma_to_axi #(
    .addr_width_p(AW), .axi_id_width_p(IDW), .axi_addr_width_p(AXAW),
    .axi_data_width_p(DW), .axi_burst_len_p(BL), .axi_id_p(0)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_write_i(dma_pkt_write_i),
    .dma_pkt_addr_i(dma_pkt_addr_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_wdata_i(dma_wdata_i), .dma_wdata_v_i(dma_wdata_v_i), .dma_wdata_yumi_o(dma_wdata_yumi_o),
    .dma_rdata_o(dma_rdata_o), .dma_rdata_v_o(dma_rdata_v_o), .dma_rdata_ready_i(dma_rdata_ready_i),
    .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
    .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
    .axi_bready_o(axi_bready_o),
    .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
    .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .err_o(err_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", tag, act, exp);
  endtask

  // Slave memory (what the DUT actually wrote) and reference memory (what the bench sent).
  logic [DW-1:0] smem [longint];
  logic [DW-1:0] rmem [longint];

  function automatic logic [DW-1:0] smem_rd(input longint a);
    if (smem.exists(a)) return smem[a];
    return DEADBEEF;
  endfunction

  function automatic logic [DW-1:0] rmem_rd(input longint a);
    if (rmem.exists(a)) return rmem[a];
    return DEADBEEF;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  bit            exp_ax_wr_q[$];
  longint        exp_ax_addr_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] wbeat_a [BL];

  bit     stall = 1'b0;
  bit     bresp_err_next = 1'b0;
  bit     stall_req = 1'b0;
  int     force_stall = 0;
  int     b_cnt = 0;
  int     rd_cnt = 0;

  // AXI slave model: drives at negedge, observes handshakes 1 time unit later.
  initial begin
    bit     aw_seen, b_pend, b_err, r_act, r_hold, err_chk;
    longint wr_base, r_base;
    int     wbeat, rbeat;
    aw_seen = 0; b_pend = 0; b_err = 0; r_act = 0; r_hold = 0; err_chk = 0;
    wr_base = 0; r_base = 0; wbeat = 0; rbeat = 0;
    axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0;
    axi_bvalid_i = 0; axi_bresp_i = 0; axi_bid_i = 0;
    axi_rvalid_i = 0; axi_rdata_i = '0; axi_rresp_i = 0; axi_rlast_i = 0; axi_rid_i = 0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        aw_seen = 0; b_pend = 0; b_err = 0; r_act = 0; r_hold = 0; err_chk = 0;
        axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0;
        axi_bvalid_i = 0; axi_rvalid_i = 0;
        continue;
      end
      if (err_chk) begin
        check("err_after_bresp", err_o, 1);
        err_chk = 0;
      end
      axi_awready_i = stall ? 1'($urandom_range(1)) : 1'b1;
      axi_wready_i  = stall ? 1'($urandom_range(1)) : 1'b1;
      axi_arready_i = stall ? 1'($urandom_range(1)) : 1'b1;
      axi_bvalid_i  = b_pend;
      axi_bresp_i   = b_err ? 2'd2 : 2'd0;
      if (r_act) begin
        if (!r_hold) axi_rvalid_i = stall ? 1'($urandom_range(1)) : 1'b1;
        axi_rdata_i = smem_rd(r_base + longint'(rbeat*BEAT_B));
        axi_rlast_i = (rbeat == BL-1);
      end else begin
        axi_rvalid_i = 0;
      end
      #1;
      if (axi_awvalid_o && axi_awready_i) begin
        if (exp_ax_addr_q.size() == 0) check("aw_unexpected", axi_awvalid_o, 0);
        else begin
          check("aw_is_write", exp_ax_wr_q.pop_front(), 1);
          check("awaddr", axi_awaddr_o, exp_ax_addr_q.pop_front());
          check("awlen", axi_awlen_o, BL-1);
          check("awsize", axi_awsize_o, $clog2(BEAT_B));
          check("awburst", axi_awburst_o, 1);
          check("awid", axi_awid_o, 0);
        end
        wr_base = longint'(axi_awaddr_o); aw_seen = 1; wbeat = 0;
      end
      if (axi_wvalid_o && axi_wready_i) begin
        check("w_after_aw", aw_seen, 1);
        check("wlast", axi_wlast_o, (wbeat == BL-1));
        check("wstrb", axi_wstrb_o, {(DW/8){1'b1}});
        smem[wr_base + longint'(wbeat*BEAT_B)] = axi_wdata_o;
        wbeat++;
        if (wbeat == BL) begin
          aw_seen = 0; b_pend = 1; b_err = bresp_err_next; bresp_err_next = 0;
        end
      end
      if (axi_bvalid_i && axi_bready_o) begin
        b_pend = 0; b_cnt++;
        if (b_err) err_chk = 1;
        b_err = 0;
      end
      if (axi_arvalid_o && axi_arready_i) begin
        if (exp_ax_addr_q.size() == 0) check("ar_unexpected", axi_arvalid_o, 0);
        else begin
          check("ar_is_read", exp_ax_wr_q.pop_front(), 0);
          check("araddr", axi_araddr_o, exp_ax_addr_q.pop_front());
          check("arlen", axi_arlen_o, BL-1);
          check("arsize", axi_arsize_o, $clog2(BEAT_B));
          check("arburst", axi_arburst_o, 1);
        end
        r_base = longint'(axi_araddr_o); r_act = 1; rbeat = 0; r_hold = 0;
      end
      if (r_act && axi_rvalid_i) begin
        if (axi_rready_o) begin
          r_hold = 0; rbeat++;
          if (rbeat == BL) r_act = 0;
        end else r_hold = 1;
      end
    end
  end

  // DMA read-data consumer: scoreboard pop plus stall-stability check.
  initial begin
    bit held;
    logic [DW-1:0] held_dat;
    held = 0; held_dat = '0;
    dma_rdata_ready_i = 0;
    forever begin
      @(negedge clk_i);
      if (force_stall > 0) begin
        dma_rdata_ready_i = 0;
        force_stall--;
      end else dma_rdata_ready_i = stall ? 1'($urandom_range(1)) : 1'b1;
      #1;
      if (!reset_n_i) begin
        held = 0;
        continue;
      end
      if (held) begin
        check("rdata_v_held", dma_rdata_v_o, 1);
        check("rdata_stable", dma_rdata_o, held_dat);
      end
      held = 0;
      if (dma_rdata_v_o) begin
        if (stall_req) begin
          stall_req = 0;
          force_stall = 5;
        end
        if (dma_rdata_ready_i) begin
          if (exp_rd_q.size() == 0) check("rd_extra_beat", dma_rdata_v_o, 0);
          else check("rdata", dma_rdata_o, exp_rd_q.pop_front());
          rd_cnt++;
        end else begin
          held = 1; held_dat = dma_rdata_o;
        end
      end
    end
  end

  task automatic idle_cycle();
    @(negedge clk_i);
    dma_pkt_v_i = 0;
    dma_wdata_v_i = 0;
    #1;
  endtask

  task automatic handshake_pkt(input bit wr, input logic [AW-1:0] addr);
    bit done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk_i);
      dma_wdata_v_i = 0;
      dma_pkt_v_i = 1; dma_pkt_write_i = wr; dma_pkt_addr_i = addr;
      #1;
      if (dma_pkt_yumi_o) done = 1;
    end
    check("pkt_accepted", done, 1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    bit done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk_i);
      dma_pkt_v_i = 0;
      dma_wdata_v_i = stall ? 1'($urandom_range(1)) : 1'b1;
      dma_wdata_i = d;
      #1;
      if (dma_wdata_v_i && dma_wdata_yumi_o) done = 1;
    end
    check("wbeat_taken", done, 1);
  endtask

  // Issue one packet, update the reference model and wait for completion.
  task automatic send_pkt(input bit wr, input logic [AW-1:0] addr);
    longint line = longint'(addr) & ~longint'(LINE_B-1);
    int b0 = b_cnt;
    int r0 = rd_cnt;
    exp_ax_wr_q.push_back(wr);
    exp_ax_addr_q.push_back(line);
    if (wr) for (int b = 0; b < BL; b++) rmem[line + longint'(b*BEAT_B)] = wbeat_a[b];
    else    for (int b = 0; b < BL; b++) exp_rd_q.push_back(rmem_rd(line + longint'(b*BEAT_B)));
    handshake_pkt(wr, addr);
    if (wr) begin
      for (int b = 0; b < BL; b++) send_beat(wbeat_a[b]);
      for (int t = 0; t < 300 && b_cnt == b0; t++) idle_cycle();
      check("wr_b_done", b_cnt - b0, 1);
    end else begin
      idle_cycle();
      for (int t = 0; t < 300 && rd_cnt - r0 < BL; t++) idle_cycle();
      check("rd_beats", rd_cnt - r0, BL);
    end
  endtask

  initial begin
    dma_pkt_v_i = 1; dma_pkt_write_i = 0; dma_pkt_addr_i = '0;
    dma_wdata_i = '0; dma_wdata_v_i = 1;

    // Reset state with valid inputs asserted.
    @(negedge clk_i); #1;
    check("rst_pkt_yumi", dma_pkt_yumi_o, 0);
    check("rst_awvalid", axi_awvalid_o, 0);
    check("rst_wvalid", axi_wvalid_o, 0);
    check("rst_arvalid", axi_arvalid_o, 0);
    check("rst_err", err_o, 0);
    @(negedge clk_i);
    dma_pkt_v_i = 0; dma_wdata_v_i = 0;
    #2 reset_n_i = 1;

    // Directed write of a full line, zero-wait slave.
    wbeat_a[0] = {(DW/32){32'hA0A0A0A0}};
    wbeat_a[1] = {(DW/32){32'hA1A1A1A1}};
    send_pkt(1, 32'h0000_0040);
    check("mem_0x40", smem_rd(64'h40), {(DW/32){32'hA0A0A0A0}});
    check("mem_0x60", smem_rd(64'h60), {(DW/32){32'hA1A1A1A1}});

    // Misaligned read address must be aligned to the line.
    send_pkt(0, 32'h0000_0047);

    // Unwritten line returns the slave's fill pattern without error.
    send_pkt(0, 32'h0001_0000);
    check("uninit_err", err_o, 0);

    // Mixed traffic with random stalls on every channel.
    stall = 1;
    for (int i = 0; i < 1000; i++) begin
      bit wr = 1'($urandom_range(1));
      logic [AW-1:0] a = 32'h1000 + 32'($urandom_range(31)) * LINE_B + 32'($urandom_range(LINE_B-1));
      for (int b = 0; b < BL; b++) wbeat_a[b] = rand_beat();
      if (!wr && $urandom_range(3) == 0) stall_req = 1;
      send_pkt(wr, a);
    end
    check("random_err", err_o, 0);
    check("rd_q_drained", exp_rd_q.size(), 0);
    check("ax_q_drained", exp_ax_addr_q.size(), 0);

    // Error response sets the sticky error; traffic continues.
    for (int b = 0; b < BL; b++) wbeat_a[b] = rand_beat();
    bresp_err_next = 1;
    send_pkt(1, 32'h0002_0000);
    send_pkt(0, 32'h0002_0000);
    repeat (3) idle_cycle();
    check("err_sticky", err_o, 1);

    // Asynchronous reset in the middle of a write burst.
    stall = 0;
    exp_ax_wr_q.push_back(1);
    exp_ax_addr_q.push_back(64'h8000);
    handshake_pkt(1, 32'h0000_8000);
    send_beat(rand_beat());
    @(posedge clk_i);
    #2;
    reset_n_i = 0; dma_pkt_v_i = 1; dma_wdata_v_i = 1;
    #1;
    check("mid_rst_pkt_yumi", dma_pkt_yumi_o, 0);
    check("mid_rst_wvalid", axi_wvalid_o, 0);
    check("mid_rst_wdata_yumi", dma_wdata_yumi_o, 0);
    check("mid_rst_awvalid", axi_awvalid_o, 0);
    check("mid_rst_bready", axi_bready_o, 0);
    check("mid_rst_arvalid", axi_arvalid_o, 0);
    check("mid_rst_rready", axi_rready_o, 0);
    check("mid_rst_rdata_v", dma_rdata_v_o, 0);
    check("mid_rst_err", err_o, 0);
    exp_ax_wr_q.delete(); exp_ax_addr_q.delete(); exp_rd_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    dma_pkt_v_i = 0; dma_wdata_v_i = 0;
    #2 reset_n_i = 1;
    send_pkt(0, 32'h0000_0040);
    check("post_rst_err", err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
